// File: rtl/axi_stream_slave_frame_rx.sv
// AXI4-Stream frame receiver: FWFT beat FIFO, tuser frame lock, pixel coordinate tagging.
// Optional FRAME_CHECK_EN macro enables sticky line-length / start-of-frame error flags.
module axi_stream_slave_frame_rx #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned FRAME_WIDTH  = 640,
    parameter int unsigned FRAME_HEIGHT = 480
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    input  logic                            s_axis_tuser,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            valid_out,
    input  logic                            ready_in,
    output logic [$clog2(FRAME_WIDTH)-1:0]  x_out,
    output logic [$clog2(FRAME_HEIGHT)-1:0] y_out,
    output logic                            sof_out,
    output logic                            eol_out,
    output logic                            frame_done,
    output logic                            line_len_err,
    output logic                            sof_err
);

    localparam int unsigned XW = $clog2(FRAME_WIDTH);
    localparam int unsigned YW = $clog2(FRAME_HEIGHT);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = DATA_WIDTH + 2;
    localparam logic [XW-1:0] X_LAST   = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(FRAME_HEIGHT - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic [0:0]    state_q, state_d;
    logic [XW-1:0] wcol_q, wcol_d, xc_q, xc_d, bcol;
    logic [YW-1:0] wline_q, wline_d, yc_q, yc_d, bline;
    logic          done_q, done_d;

    logic          full, empty, drop_ok, push, pop;
    logic [EW-1:0] head;
    logic          head_user, head_last;

    assign full    = (cnt_q == CNT_FULL);
    assign empty   = (cnt_q == '0);
    // Pre-lock beats without tuser are swallowed regardless of FIFO occupancy.
    assign drop_ok = (state_q == ST_IDLE) && !s_axis_tuser;

    assign s_axis_tready = !rst && (!full || drop_ok);
    assign push          = s_axis_tvalid && s_axis_tready && !drop_ok;
    assign valid_out     = !rst && !empty;
    assign pop           = valid_out && ready_in;

    assign head      = mem_q[rd_ptr_q];
    assign head_user = head[EW-1];
    assign head_last = head[EW-2];

    assign data_out   = valid_out ? head[DATA_WIDTH-1:0] : '0;
    assign sof_out    = valid_out && head_user;
    assign eol_out    = valid_out && head_last;
    assign x_out      = sof_out ? '0 : xc_q;
    assign y_out      = sof_out ? '0 : yc_q;
    assign frame_done = done_q;

    always_comb begin
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Write-side position of the incoming beat; tuser always restarts at (0,0).
    always_comb begin
        state_d = state_q;
        wcol_d  = wcol_q;
        wline_d = wline_q;
        bcol    = s_axis_tuser ? '0 : wcol_q;
        bline   = s_axis_tuser ? '0 : wline_q;
        if (push) begin
            state_d = ST_ACTIVE;
            if (s_axis_tlast) begin
                wcol_d = '0;
                if (bline == Y_LAST) begin
                    wline_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    wline_d = bline + 1'b1;
                end
            end else begin
                wcol_d  = (bcol == X_LAST) ? X_LAST : bcol + 1'b1;
                wline_d = bline;
            end
        end
    end

    always_comb begin
        xc_d   = xc_q;
        yc_d   = yc_q;
        done_d = 1'b0;
        if (pop) begin
            if (head_last) begin
                xc_d = '0;
                if (y_out == Y_LAST) begin
                    yc_d   = '0;
                    done_d = 1'b1;
                end else begin
                    yc_d = y_out + 1'b1;
                end
            end else begin
                xc_d = (x_out == X_LAST) ? X_LAST : x_out + 1'b1;
                yc_d = y_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
            wcol_q   <= '0;
            wline_q  <= '0;
            xc_q     <= '0;
            yc_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            wcol_q  <= wcol_d;
            wline_q <= wline_d;
            xc_q    <= xc_d;
            yc_q    <= yc_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
    end

`ifdef FRAME_CHECK_EN
    logic len_err_q, sof_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            len_err_q <= 1'b0;
            sof_err_q <= 1'b0;
        end else begin
            if (push && (s_axis_tlast != (bcol == X_LAST))) len_err_q <= 1'b1;
            if (push && s_axis_tuser && (state_q == ST_ACTIVE)) sof_err_q <= 1'b1;
        end
    end

    assign line_len_err = len_err_q;
    assign sof_err      = sof_err_q;
`else
    assign line_len_err = 1'b0;
    assign sof_err      = 1'b0;
`endif

endmodule
